// File: rtl/hopfield_seq_ctrl.sv
// Sequencer for the Hopfield core: loads a probe pattern from UART, runs update sweeps
// until stable or MAX_ITER, then streams the settled pattern back. Option macro: HOP_STATUS_EN.
module hopfield_seq_ctrl #(
    parameter int unsigned N        = 64,
    parameter int unsigned MAX_ITER = 32,
    parameter int unsigned AW       = $clog2(N / 8)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          st_we,
    output logic [AW-1:0] st_addr,
    output logic [7:0]    st_wdata,
    input  logic [7:0]    st_rdata,
    output logic          upd_start,
    input  logic          upd_done,
    input  logic          upd_changed,
    output logic [9:0]    debug
);

    localparam int unsigned NB       = N / 8;
    localparam logic [AW-1:0] LAST   = AW'(NB - 1);
    localparam logic [7:0] ITER_LIM  = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_WAIT    = 3'd1,
        S_RUN     = 3'd2,
        S_WAITUPD = 3'd3,
        S_SEND_RD = 3'd4,
        S_SEND_TX = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] count;
    logic [7:0]    iter;
    logic          converged;
    logic          rx_drop;
    logic [7:0]    iter_inc_c;
`ifdef HOP_STATUS_EN
    logic          status_phase;
`endif

    assign iter_inc_c = (iter == 8'hFF) ? iter : iter + 8'd1;
    assign debug      = {iter[4:0], rx_drop, converged, 3'(state)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            count     <= '0;
            iter      <= '0;
            converged <= 1'b0;
            rx_drop   <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            st_we     <= 1'b0;
            st_addr   <= '0;
            st_wdata  <= '0;
            upd_start <= 1'b0;
`ifdef HOP_STATUS_EN
            status_phase <= 1'b0;
`endif
        end else begin
            st_we     <= 1'b0;
            upd_start <= 1'b0;
            if (rx_valid && state != S_LOAD) begin
                rx_drop <= 1'b1;
            end
            case (state)
                S_LOAD: begin
                    if (rx_valid) begin
                        st_we    <= 1'b1;
                        st_addr  <= count;
                        st_wdata <= rx_data;
                        if (count == LAST) begin
                            count <= '0;
                            state <= S_WAIT;
                        end else begin
                            count <= count + AW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // first sweep is launched on the RUN entry edge itself
                    if (start) begin
                        state     <= S_RUN;
                        upd_start <= 1'b1;
                        iter      <= '0;
                        converged <= 1'b0;
                        st_addr   <= '0;
                    end
                end
                S_RUN: begin
                    state <= S_WAITUPD;
                    if (!upd_start) begin
                        upd_start <= 1'b1;
                    end
                end
                S_WAITUPD: begin
                    if (upd_done) begin
                        iter <= iter_inc_c;
                        if (!upd_changed) begin
                            converged <= 1'b1;
                            state     <= S_SEND_RD;
                            st_addr   <= count;
                        end else if (iter_inc_c == ITER_LIM) begin
                            state   <= S_SEND_RD;
                            st_addr <= count;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_SEND_RD: begin
                    tx_data  <= st_rdata;
                    tx_valid <= 1'b1;
                    state    <= S_SEND_TX;
                end
                S_SEND_TX: begin
                    if (tx_ready) begin
`ifdef HOP_STATUS_EN
                        // trailing status byte reuses the handshake without a memory read
                        if (status_phase) begin
                            tx_valid     <= 1'b0;
                            status_phase <= 1'b0;
                            count        <= '0;
                            state        <= S_LOAD;
                        end else if (count == LAST) begin
                            tx_data      <= {converged, iter[6:0]};
                            status_phase <= 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                            count    <= count + AW'(1);
                            st_addr  <= count + AW'(1);
                            state    <= S_SEND_RD;
                        end
`else
                        tx_valid <= 1'b0;
                        if (count == LAST) begin
                            count <= '0;
                            state <= S_LOAD;
                        end else begin
                            count   <= count + AW'(1);
                            st_addr <= count + AW'(1);
                            state   <= S_SEND_RD;
                        end
`endif
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_seq_ctrl.sv
// Self-checking bench for hopfield_seq_ctrl: directed steps with randomized patterns and
// sweep outcomes, checked against a run-level reference model.
module tb_hopfield_seq_ctrl;

    localparam int N        = 64;
    localparam int NB       = N / 8;
    localparam int MAX_ITER = 4;
    localparam int AW       = 3;
`ifdef HOP_STATUS_EN
    localparam int NTX = NB + 1;
`else
    localparam int NTX = NB;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          st_we;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_wdata;
    logic [7:0]    st_rdata;
    logic          upd_start;
    logic          upd_done = 1'b0;
    logic          upd_changed = 1'b0;
    logic [9:0]    debug;

    hopfield_seq_ctrl #(.N(N), .MAX_ITER(MAX_ITER), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .st_we(st_we), .st_addr(st_addr), .st_wdata(st_wdata), .st_rdata(st_rdata),
        .upd_start(upd_start), .upd_done(upd_done), .upd_changed(upd_changed),
        .debug(debug)
    );

    always #5 clk = ~clk;

    // neuron-state memory: registered address from the DUT, read data follows it
    logic [7:0] mem [NB];
    assign st_rdata = mem[st_addr];
    always @(posedge clk) if (st_we) mem[st_addr] <= st_wdata;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         us_cnt  = 0;
    int         dbl_err = 0;
    int         stab_err = 0;
    logic       prev_us = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] txq [$];
    logic [7:0] pat [NB];
    bit         chg_seq [16];
    int         exp_iter;
    bit         exp_conv;

    always @(posedge clk) begin
        if (upd_start) us_cnt++;
        if (upd_start && prev_us) dbl_err++;
        prev_us = upd_start;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (prev_hold && tx_valid && tx_data !== prev_data) stab_err++;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit gaps);
        for (int i = 0; i < NB; i++) begin
            rx_data  = pat[i];
            rx_valid = 1'b1;
            tick();
            chk("load_we", 32'(st_we), 1);
            chk("load_addr", 32'(st_addr), i);
            chk("load_wdata", 32'(st_wdata), 32'(pat[i]));
            rx_valid = 1'b0;
            if (gaps && $urandom_range(0, 1) == 1 && i != NB - 1) begin
                tick();
                chk("load_gap_we", 32'(st_we), 0);
            end
        end
        chk("load_to_wait", 32'(debug[2:0]), 1);
    endtask

    // reference: iterations and convergence from the sweep outcome list
    task automatic model_run();
        exp_iter = 0;
        exp_conv = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_iter++;
            if (!chg_seq[k]) begin
                exp_conv = 1'b1;
                break;
            end
            if (exp_iter == MAX_ITER) break;
        end
    endtask

    task automatic do_run(input bit inject);
        int us0;
        model_run();
        us0 = us_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_upd_start", 32'(upd_start), 1);
        chk("start_run_state", 32'(debug[2:0]), 2);
        for (int k = 0; k < exp_iter; k++) begin
            if (k > 0) begin
                chk("resweep_run", 32'(debug[2:0]), 2);
                chk("resweep_us_low", 32'(upd_start), 0);
                tick();
                chk("resweep_us_t2", 32'(upd_start), 1);
            end
            if (inject && k == 0) rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            chk("waitupd_state", 32'(debug[2:0]), 3);
            if (inject && k == 0) begin
                chk("drop_no_we", 32'(st_we), 0);
                chk("drop_flag", 32'(debug[4]), 1);
            end
            repeat ($urandom_range(0, 2)) tick();
            upd_done    = 1'b1;
            upd_changed = chg_seq[k];
            tick();
            upd_done    = 1'b0;
            upd_changed = 1'b0;
        end
        chk("send_rd_state", 32'(debug[2:0]), 4);
        chk("send_rd_addr", 32'(st_addr), 0);
        chk("sweep_count", us_cnt - us0, exp_iter);
        chk("converged", 32'(debug[3]), 32'(exp_conv));
        chk("iter", 32'(debug[9:5]), exp_iter);
        tick();
        chk("first_tx_valid", 32'(tx_valid), 1);
        chk("first_tx_data", 32'(tx_data), 32'(pat[0]));
    endtask

    task automatic recv(input int bp_idx);
        int         budget;
        bit         bp_done;
        logic [7:0] hold;
        logic [7:0] exp_b;
        budget  = 2000;
        bp_done = 1'b0;
        while (txq.size() < NTX && budget > 0) begin
            if (txq.size() == bp_idx && tx_valid && !bp_done) begin
                tx_ready = 1'b0;
                hold = tx_data;
                repeat (10) tick();
                chk("bp_valid_held", 32'(tx_valid), 1);
                chk("bp_data_stable", 32'(tx_data), 32'(hold));
                chk("bp_no_accept", txq.size(), bp_idx);
                bp_done = 1'b1;
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
            budget--;
        end
        tx_ready = 1'b0;
        chk("tx_count", txq.size(), NTX);
        chk("back_to_load", 32'(debug[2:0]), 0);
        tick();
        chk("tx_idle", 32'(tx_valid), 0);
        chk("no_extra_tx", txq.size(), NTX);
        chk("hold_converged", 32'(debug[3]), 32'(exp_conv));
        chk("hold_iter", 32'(debug[9:5]), exp_iter);
        for (int i = 0; i < NTX && i < txq.size(); i++) begin
            exp_b = (i < NB) ? pat[i] : {exp_conv, 7'(exp_iter)};
            chk("tx_byte", 32'(txq[i]), 32'(exp_b));
        end
        txq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_debug", 32'(debug), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_st_we", 32'(st_we), 0);
        chk("rst_upd_start", 32'(upd_start), 0);

        // start and upd_done in LOAD are ignored
        start = 1'b1; upd_done = 1'b1; upd_changed = 1'b1;
        tick();
        start = 1'b0; upd_done = 1'b0; upd_changed = 1'b0;
        chk("ign_start_state", 32'(debug[2:0]), 0);
        chk("ign_start_us", 32'(upd_start), 0);
        chk("ign_start_we", 32'(st_we), 0);
        tick();
        chk("ign_start_us2", 32'(upd_start), 0);

        // directed load 0x01..0x08, converge after changed=1,1,0, backpressure on byte 2
        for (int i = 0; i < NB; i++) pat[i] = 8'(i + 1);
        load(1'b0);
        chk("rx_drop_clear", 32'(debug[4]), 0);
        chg_seq[0] = 1'b1; chg_seq[1] = 1'b1; chg_seq[2] = 1'b0;
        do_run(1'b1);
        chk("dir_iter3", exp_iter, 3);
        recv(2);

        // iteration limit: always changed
        for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
        load(1'b1);
        for (int k = 0; k < 16; k++) chg_seq[k] = 1'b1;
        do_run(1'b0);
        recv(-1);

        // randomized runs
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
            load(1'b1);
            for (int k = 0; k < 16; k++) chg_seq[k] = ($urandom_range(0, 2) != 0);
            do_run(1'b0);
            recv(int'($urandom_range(0, NTX - 1)));
        end

        // reset during WAITUPD, late upd_done must be ignored
        for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
        load(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_state", 32'(debug[2:0]), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        upd_done = 1'b1; upd_changed = 1'b1;
        tick();
        upd_done = 1'b0; upd_changed = 1'b0;
        chk("mid_rst_debug", 32'(debug), 0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        chk("mid_rst_st_addr", 32'(st_addr), 0);
        chk("mid_rst_st_wdata", 32'(st_wdata), 0);
        tick();
        chk("mid_rst_us", 32'(upd_start), 0);
        chk("mid_rst_state", 32'(debug[2:0]), 0);

        // converged at 3 after reset (status byte 0x83 when enabled)
        for (int i = 0; i < NB; i++) pat[i] = 8'($urandom);
        load(1'b0);
        chg_seq[0] = 1'b1; chg_seq[1] = 1'b1; chg_seq[2] = 1'b0;
        do_run(1'b0);
        recv(-1);

        chk("no_double_upd_start", dbl_err, 0);
        chk("tx_data_stable", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hopfield_seq_ctrl.md
# hopfield_seq_ctrl

Top-level sequencer for the Hopfield network core on the DE1-SoC build. Collects an N-bit probe pattern from the UART receiver, writes it into the core's neuron-state memory, then on the start key repeatedly triggers network update sweeps until the state stops changing or an iteration limit is hit. It then streams the settled pattern back through the UART transmitter and drives a 10-bit status word onto the LEDs.

## Interface
- N, 64: neuron count; must be a multiple of 8. NB = N/8 pattern bytes.
- MAX_ITER, 32: maximum update sweeps per run, 1..255.
- AW, $clog2(NB): state-memory byte address width.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, synchronous, active-high.
- start  in  1  debounced single-cycle start pulse, active-high.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter can accept a byte.
- st_we  out  1  neuron-state byte write enable.
- st_addr  out  AW  neuron-state byte address.
- st_wdata  out  8  neuron-state write data, bit k = neuron 8*addr+k.
- st_rdata  in  8  neuron-state read data, valid 1 cycle after st_addr.
- upd_start  out  1  one-cycle pulse, starts one full update sweep.
- upd_done  in  1  one-cycle pulse, sweep finished.
- upd_changed  in  1  valid with upd_done: at least one neuron flipped.
- debug  out  10  status: [2:0] state code, [3] converged, [4] rx_drop, [9:5] iter[4:0].

## Operation
- States (code): LOAD(0), WAIT(1), RUN(2), WAITUPD(3), SEND_RD(4), SEND_TX(5).
- LOAD: each rx_valid registers rx_data into st_wdata, drives st_we=1 for one cycle at st_addr=byte count, and increments the count. After byte NB-1, go to WAIT and clear the count.
- WAIT: start goes to RUN. iter and converged are cleared on entry to RUN.
- RUN: assert upd_start for one cycle, go to WAITUPD.
- WAITUPD: on upd_done, iter increments (saturating at 255).
  - upd_changed=0: set converged=1, go to SEND_RD.
  - Else, if the new iter == MAX_ITER: go to SEND_RD with converged=0.
  - Else: return to RUN.
- SEND_RD: drive st_addr=byte count for one cycle, then go to SEND_TX.
- SEND_TX:
  - Capture st_rdata into tx_data and assert tx_valid.
  - On tx_valid&&tx_ready, deassert tx_valid and increment the count.
  - After byte NB-1, go to LOAD (count cleared). Otherwise return to SEND_RD.
- tx_data is stable while tx_valid=1.
- rx_valid outside LOAD discards the byte and sets sticky rx_drop. rx_drop is cleared only by rst.
- start outside WAIT is ignored.
- upd_done outside WAITUPD is ignored.
- converged and iter hold their values through SEND and LOAD until the next RUN entry.

## Timing
- Reset values: tx_valid=0, tx_data=0, st_we=0, st_addr=0, st_wdata=0, upd_start=0, debug=0. State is LOAD, count=0, iter=0.
- Rx to write: st_we is high the cycle after rx_valid. Back-to-back rx_valid on consecutive cycles is supported.
- The last LOAD write and entry to WAIT happen in the same cycle.
- Start to sweep: start in cycle t gives RUN at t+1 and upd_start=1 at t+1.
- Sweep to sweep: upd_done(changed=1) at t gives upd_start at t+2.
- Done to transmit: upd_done at t gives st_addr driven at t+1 and tx_valid=1 at t+2.
- Each byte takes at least 2 cycles (SEND_RD plus one SEND_TX cycle with tx_ready=1).
- upd_start and st_we are never high for two consecutive cycles from the same event.
- A rst assertion mid-run takes effect on the next edge: all outputs return to reset values and any in-flight sweep result is ignored.

## Configuration
- HOP_STATUS_EN defined:
  - After the NB pattern bytes, SEND transmits one extra status byte: {converged, iter[6:0]}.
  - Uses the same tx_valid/tx_ready handshake, with no st_addr read for that byte.
  - The return to LOAD follows acceptance of the status byte.
- Undefined: exactly NB bytes are sent, and debug is the only place convergence information appears.

## Test plan
- Load: 8 rx bytes 0x01..0x08 (N=64) -> 8 st_we pulses at addr 0..7 with matching st_wdata, state WAIT, debug[2:0]=1.
- Converge: start, then model returns changed=1, 1, 0 -> exactly 3 upd_start pulses, converged=1, iter=3, then 8 tx bytes equal to the memory contents.
- Limit: MAX_ITER=4, model always returns changed=1 -> 4 upd_start pulses, converged=0, transmission begins after the 4th upd_done.
- Backpressure: tx_ready low for 10 cycles on byte 2 -> tx_valid held, tx_data stable, no byte skipped or duplicated.
- Drop/ignore: rx_valid during RUN and a start pulse during LOAD -> no st_we, rx_drop=1, state unchanged.
- Reset: rst asserted in WAITUPD, then upd_done arrives -> outputs at reset values, state LOAD, iter=0. With HOP_STATUS_EN, a converged-at-3 run sends a 9th byte of 0x83.
